ram_bist_ctrl: RTL
==================

# ram_bist_ctrl

March C- built-in self-test controller that drives the command port of the 16x8 synchronous RAM and checks its registered read data. It sits directly upstream of the RAM, multiplexing between a functional user port (idle) and its own test sequencer (busy). On completion it reports pass/fail and captures the first failing address, element and read value for debug.

## Interface

- ADDR_W, 4, RAM address width; depth is 2^ADDR_W.
- DATA_W, 8, RAM data width.
- PATTERN, 8'h00, background word written as "0"; "1" is ~PATTERN.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the test; sampled only when idle.
- usr_we  in  1  functional write enable, forwarded when idle.
- usr_re  in  1  functional read enable, forwarded when idle.
- usr_addr  in  ADDR_W  functional address, forwarded when idle.
- usr_din  in  DATA_W  functional write data, forwarded when idle.
- ram_dout  in  DATA_W  RAM registered read data (valid the cycle after re).
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- busy  out  1  test in progress; user port ignored.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  sticky: last test found no mismatch.
- fail  out  1  sticky: last test found at least one mismatch.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_elem  out  3  March element (0..5) of first mismatch.
- fail_data  out  DATA_W  ram_dout value at first mismatch.

## Operation

- States: IDLE, RUN, CHECK. IDLE: ram_* = usr_* combinationally; busy=0.
- IDLE + start=1 -> RUN; busy=1; pass, fail, fail_* cleared. start while busy ignored.
- RUN issues one RAM operation per cycle from registered bist signals; ram_we and ram_re never both 1.
- Elements (0 = PATTERN, 1 = ~PATTERN), up = addr 0->15, down = 15->0:
  - M0 up: w0. M1 up: r0,w1. M2 up: r1,w0. M3 down: r0,w1. M4 down: r1,w0. M5 up: r0.
  - Two-op elements: read then write to same address in consecutive cycles, then next address.
- Total 16+32+32+32+32+16 = 160 operations. After last op (M5 r0 at addr 15) -> CHECK for one cycle -> IDLE.
- Compare pipeline: each read registers expected word, element and address; following cycle compares ram_dout against it.
- Mismatch: fail=1; fail_addr/fail_elem/fail_data captured only on the first mismatch of the run. Test never aborts early.
- End: done=1 one cycle; pass = ~fail; both hold until next start or reset.
- RAM contents after a test: all PATTERN. Block never drives the RAM's own reset.

## Timing

- Reset (rst=0, asynchronous): state IDLE; busy, done, pass, fail=0; fail_addr, fail_elem, fail_data=0; internal bist ram_we/re/addr/din=0 (ram_* then follow usr_*).
- Reset mid-run: immediate return to IDLE, results cleared, no done pulse.
- Start sampled at edge E0: busy=1 after E0; RAM executes ops at E1..E160; last compare at E161; done=1, busy=0 in the cycle after E161 (161 busy cycles).
- Read latency assumed exactly 1 cycle (RAM registers dout on the edge where re=1).
- Bypass path is purely combinational; no added latency on the functional port.

## Test plan

- Good RAM model, PATTERN=00, start pulse -> busy high 161 cycles, done one pulse, pass=1, fail=0, fail_* = 0.
- RAM model with addr 5 bit 3 stuck-at-1 -> fail=1, pass=0, fail_addr=5, fail_elem=1, fail_data=8'h08.
- RAM model ignoring writes to addr 9 (holds 00) -> fail_addr=9, fail_elem=2, fail_data=8'h00; run completes with done pulse.
- PATTERN=8'h55 on good RAM -> ram_din alternates 55/AA per element, pass=1; memory reads 55 at all addresses afterwards.
- rst low at cycle 50 of a run -> busy, fail, pass to 0 immediately, no done; rerun after release -> pass=1.
- Idle bypass: usr_we with addr 3, din A5, then usr_re addr 3 -> ram_dout=A5 next cycle; start pulses and usr_we during busy -> no effect on ram_we/ram_din sequence, test still passes.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// March C- self-test controller sitting in front of a 16x8 synchronous RAM.
// Latency: bypass is combinational; a test takes 161 busy cycles from start to done.
// Backpressure: none; the user port is ignored while busy and start is sampled only when idle.
//
// Ports:
//   clk, rst (async active-low)      clock and reset
//   start                            one-cycle test request (idle only)
//   usr_we/usr_re/usr_addr/usr_din   functional port, forwarded to the RAM when idle
//   ram_dout                         RAM registered read data (one cycle after re)
//   ram_we/ram_re/ram_addr/ram_din   RAM command port
//   busy, done, pass, fail           status; pass/fail sticky until next start/reset
//   fail_addr/fail_elem/fail_data    first mismatch capture
module ram_bist_ctrl #(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              usr_we,
    input  logic              usr_re,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [DATA_W-1:0] usr_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [DATA_W-1:0] P0       = PATTERN;
    localparam logic [DATA_W-1:0] P1       = ~PATTERN;

    state_t              state;

    // Registered command for the operation currently presented to the RAM.
    logic                bist_we;
    logic                bist_re;
    logic [ADDR_W-1:0]   bist_addr;
    logic [DATA_W-1:0]   bist_din;
    logic [2:0]          op_elem;   // March element of the current op
    logic                op_ph;     // 0 = read half, 1 = write half of a two-op element

    // Compare stage: captured with each read, evaluated the following cycle.
    logic                chk_vld;
    logic [DATA_W-1:0]   chk_exp;
    logic [2:0]          chk_elem;
    logic [ADDR_W-1:0]   chk_addr;
    logic                mismatch;

    logic [2:0]          nx_elem;
    logic [ADDR_W-1:0]   nx_addr;
    logic                nx_ph;
    logic                last_op;

    // {we, re, din} for an element/phase. Reads drive din as zero.
    function automatic logic [DATA_W+1:0] op_decode(input logic [2:0] e, input logic ph);
        logic [DATA_W+1:0] r;
        r = '0;
        case (e)
            3'd0:       r = {1'b1, 1'b0, P0};
            3'd1, 3'd3: r = ph ? {1'b1, 1'b0, P1} : {1'b0, 1'b1, {DATA_W{1'b0}}};
            3'd2, 3'd4: r = ph ? {1'b1, 1'b0, P0} : {1'b0, 1'b1, {DATA_W{1'b0}}};
            3'd5:       r = {1'b0, 1'b1, {DATA_W{1'b0}}};
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Value every read of an element expects: M2/M4 read the inverted background.
    function automatic logic [DATA_W-1:0] exp_word(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? P1 : P0;
    endfunction

    // Next-operation sequencing. Two-op elements stay on the same address for
    // the write half; M3/M4 walk downward, all others upward.
    always_comb begin
        nx_elem = op_elem;
        nx_addr = bist_addr;
        nx_ph   = 1'b0;
        last_op = 1'b0;
        if (op_elem >= 3'd1 && op_elem <= 3'd4 && !op_ph) begin
            nx_ph = 1'b1;
        end else if (op_elem == 3'd3 || op_elem == 3'd4) begin
            if (bist_addr == '0) begin
                nx_elem = op_elem + 3'd1;
                nx_addr = (op_elem == 3'd3) ? ADDR_MAX : '0;
            end else begin
                nx_addr = bist_addr - 1'b1;
            end
        end else begin
            if (bist_addr == ADDR_MAX) begin
                if (op_elem == 3'd5) begin
                    last_op = 1'b1;
                end else begin
                    nx_elem = op_elem + 3'd1;
                    nx_addr = (op_elem == 3'd2) ? ADDR_MAX : '0;
                end
            end else begin
                nx_addr = bist_addr + 1'b1;
            end
        end
    end

    assign mismatch = chk_vld && (ram_dout != chk_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            bist_we   <= 1'b0;
            bist_re   <= 1'b0;
            bist_addr <= '0;
            bist_din  <= '0;
            op_elem   <= '0;
            op_ph     <= 1'b0;
            chk_vld   <= 1'b0;
            chk_exp   <= '0;
            chk_elem  <= '0;
            chk_addr  <= '0;
        end else begin
            done <= 1'b0;

            chk_vld  <= (state == RUN) && bist_re;
            chk_exp  <= exp_word(op_elem);
            chk_elem <= op_elem;
            chk_addr <= bist_addr;

            // Only the first mismatch of a run is captured; later ones just keep fail set.
            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= chk_addr;
                    fail_elem <= chk_elem;
                    fail_data <= ram_dout;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        fail_data <= '0;
                        op_elem   <= 3'd0;
                        op_ph     <= 1'b0;
                        bist_addr <= '0;
                        {bist_we, bist_re, bist_din} <= op_decode(3'd0, 1'b0);
                    end
                end
                RUN: begin
                    if (last_op) begin
                        state     <= CHECK;
                        bist_we   <= 1'b0;
                        bist_re   <= 1'b0;
                        bist_addr <= '0;
                        bist_din  <= '0;
                    end else begin
                        op_elem   <= nx_elem;
                        op_ph     <= nx_ph;
                        bist_addr <= nx_addr;
                        {bist_we, bist_re, bist_din} <= op_decode(nx_elem, nx_ph);
                    end
                end
                CHECK: begin
                    // Final read's compare resolves on this edge, so fold it into pass.
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= !(fail || mismatch);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Functional bypass when idle; sequencer owns the RAM otherwise.
    assign ram_we   = (state == IDLE) ? usr_we   : bist_we;
    assign ram_re   = (state == IDLE) ? usr_re   : bist_re;
    assign ram_addr = (state == IDLE) ? usr_addr : bist_addr;
    assign ram_din  = (state == IDLE) ? usr_din  : bist_din;

endmodule
